decode_execute_reg: RTL and testbench
=====================================

# decode_execute_reg

Pipeline register between the Decode (D) and Execute (E) stages of the five-stage RISC-V core. It captures the decoded control word, operands, register specifiers and PC values at each clock edge. It supports a hold (stall) and a bubble-inserting flush, and its `Rs1E`/`Rs2E`/`RdE`/`RegWriteE` outputs are what the forwarding hazard unit compares against the M and W stages. It also keeps a saturating count of bubbles entering E for performance monitoring.

## Interface
Parameters:
- XLEN, 32, datapath width.
- CNT_W, 16, bubble counter width.

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- StallE  in  1  hold all E-stage registers.
- FlushE  in  1  load a bubble (load-use or taken branch/jump).
- ClearCount  in  1  synchronous clear of BubbleCount.
- ValidD  in  1  D stage holds a real instruction.
- RegWriteD, MemWriteD, JumpD, BranchD, ALUSrcD  in  1 each  control bits.
- ResultSrcD  in  2  result select.
- ALUControlD  in  3  ALU operation.
- RD1D, RD2D, ImmExtD, PCD, PCPlus4D  in  XLEN each  operands, immediate, PCs.
- Rs1D, Rs2D, RdD  in  5 each  register specifiers.
- RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, ResultSrcE, ALUControlE, RD1E, RD2E, ImmExtE, PCE, PCPlus4E, Rs1E, Rs2E, RdE  out  same widths as the D counterparts  registered copies.
- ValidE  out  1  E stage holds a real instruction.
- BubbleCount  out  CNT_W  bubbles entered into E since reset or clear.

## Operation
- Each cycle's update is chosen by priority: rst, then FlushE, then StallE, then normal load.
- **rst:** every output register goes to 0, including BubbleCount and ValidE.
- **FlushE=1:** every E output goes to 0 on the next edge. This includes the data fields and Rs1E/Rs2E/RdE, so a bubble can never match a forwarding comparison. ValidE goes to 0.
  - FlushE overrides StallE when both are asserted.
- **StallE=1, FlushE=0:** all E registers hold their values, including ValidE.
- **Normal load:** every E register takes its D value.
  - ValidE takes ValidD.
  - If ValidD=0, all control bits (RegWrite, MemWrite, Jump, Branch) are forced to 0. Data and specifier fields still load.
- **Bubble event:** an edge where ValidE becomes 0 through FlushE, or through a normal load with ValidD=0.
  - A stalled cycle is never a bubble event, even while ValidE=0.
- **BubbleCount:**
  - Increments by 1 on each bubble event.
  - Saturates at 2^CNT_W−1 and never wraps.
  - ClearCount=1 sets it to 0 on the next edge; clear wins over a simultaneous increment.
- Rs1E and Rs2E are always full 5-bit values, never truncated.

## Timing
- Latency is exactly one cycle from D input to E output; there is no combinational path from D to E.
- Outputs change only on the rising clk edge or on rst assertion.
- rst is asynchronous. Asserting it mid-stall or mid-flush clears all outputs immediately, without waiting for a clock edge.
- After rst deasserts, the first edge performs whatever its control inputs select.
- StallE and FlushE are sampled at the edge. Each one affects only that single edge; nothing is remembered across cycles.
- BubbleCount updates on the same edge as the ValidE transition that caused it.

## Test plan
- **Reset:** drive all D inputs to nonzero and pulse rst asynchronously between edges -> all outputs, including BubbleCount, are 0 immediately.
- **Normal pass-through:** set RdD=5, Rs1D=3, RD1D=0xDEADBEEF, RegWriteD=1, ValidD=1 -> one edge later RdE=5, Rs1E=3, RD1E=0xDEADBEEF, RegWriteE=1, ValidE=1, and BubbleCount is unchanged.
- **Stall:** load RdD=7, then hold StallE=1 for 3 cycles while changing RdD to 9 -> RdE stays 7 for all 3 cycles and BubbleCount does not change. RdE=9 appears one edge after StallE drops.
- **Flush overrides stall:** assert FlushE=1 and StallE=1 together with RegWriteD=1, RdD=4 -> after the edge RegWriteE=0, RdE=0, Rs1E=0, RD1E=0, ValidE=0, and BubbleCount goes from 0 to 1.
- **Invalid D:** ValidD=0 with RegWriteD=1, MemWriteD=1, RdD=6 -> RegWriteE=0, MemWriteE=0, RdE=6, ValidE=0, and BubbleCount increments.
- **Saturation and clear:** with CNT_W=4, apply 20 consecutive flushes -> BubbleCount holds at 15. Then assert ClearCount together with FlushE -> BubbleCount=0.

Source files
------------

// File: rtl/decode_execute_reg.sv
// rtl/decode_execute_reg.sv - D/E pipeline register with stall, bubble flush and bubble counter
module decode_execute_reg #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             StallE,
    input  logic             FlushE,
    input  logic             ClearCount,
    input  logic             ValidD,
    input  logic             RegWriteD,
    input  logic             MemWriteD,
    input  logic             JumpD,
    input  logic             BranchD,
    input  logic             ALUSrcD,
    input  logic [1:0]       ResultSrcD,
    input  logic [2:0]       ALUControlD,
    input  logic [XLEN-1:0]  RD1D,
    input  logic [XLEN-1:0]  RD2D,
    input  logic [XLEN-1:0]  ImmExtD,
    input  logic [XLEN-1:0]  PCD,
    input  logic [XLEN-1:0]  PCPlus4D,
    input  logic [4:0]       Rs1D,
    input  logic [4:0]       Rs2D,
    input  logic [4:0]       RdD,
    output logic             RegWriteE,
    output logic             MemWriteE,
    output logic             JumpE,
    output logic             BranchE,
    output logic             ALUSrcE,
    output logic [1:0]       ResultSrcE,
    output logic [2:0]       ALUControlE,
    output logic [XLEN-1:0]  RD1E,
    output logic [XLEN-1:0]  RD2E,
    output logic [XLEN-1:0]  ImmExtE,
    output logic [XLEN-1:0]  PCE,
    output logic [XLEN-1:0]  PCPlus4E,
    output logic [4:0]       Rs1E,
    output logic [4:0]       Rs2E,
    output logic [4:0]       RdE,
    output logic             ValidE,
    output logic [CNT_W-1:0] BubbleCount
);

    logic bubble;
    logic cnt_full;

    // A bubble enters E on a flush or on a normal load of an empty D slot
    assign bubble   = FlushE || (!StallE && !ValidD);
    assign cnt_full = (BubbleCount == {CNT_W{1'b1}});

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            RegWriteE   <= 1'b0;
            MemWriteE   <= 1'b0;
            JumpE       <= 1'b0;
            BranchE     <= 1'b0;
            ALUSrcE     <= 1'b0;
            ResultSrcE  <= '0;
            ALUControlE <= '0;
            RD1E        <= '0;
            RD2E        <= '0;
            ImmExtE     <= '0;
            PCE         <= '0;
            PCPlus4E    <= '0;
            Rs1E        <= '0;
            Rs2E        <= '0;
            RdE         <= '0;
            ValidE      <= 1'b0;
        end else if (FlushE) begin
            // Specifiers are zeroed too so a bubble never matches a forwarding compare
            RegWriteE   <= 1'b0;
            MemWriteE   <= 1'b0;
            JumpE       <= 1'b0;
            BranchE     <= 1'b0;
            ALUSrcE     <= 1'b0;
            ResultSrcE  <= '0;
            ALUControlE <= '0;
            RD1E        <= '0;
            RD2E        <= '0;
            ImmExtE     <= '0;
            PCE         <= '0;
            PCPlus4E    <= '0;
            Rs1E        <= '0;
            Rs2E        <= '0;
            RdE         <= '0;
            ValidE      <= 1'b0;
        end else if (!StallE) begin
            RegWriteE   <= RegWriteD & ValidD;
            MemWriteE   <= MemWriteD & ValidD;
            JumpE       <= JumpD & ValidD;
            BranchE     <= BranchD & ValidD;
            ALUSrcE     <= ALUSrcD;
            ResultSrcE  <= ResultSrcD;
            ALUControlE <= ALUControlD;
            RD1E        <= RD1D;
            RD2E        <= RD2D;
            ImmExtE     <= ImmExtD;
            PCE         <= PCD;
            PCPlus4E    <= PCPlus4D;
            Rs1E        <= Rs1D;
            Rs2E        <= Rs2D;
            RdE         <= RdD;
            ValidE      <= ValidD;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            BubbleCount <= '0;
        end else if (ClearCount) begin
            BubbleCount <= '0;
        end else if (bubble && !cnt_full) begin
            BubbleCount <= BubbleCount + 1'b1;
        end
    end

endmodule

// File: tb/tb_decode_execute_reg.sv
// tb/tb_decode_execute_reg.sv - scoreboard bench for decode_execute_reg with a behavioural model
module tb_decode_execute_reg;

    localparam int XLEN  = 32;
    localparam int CNT_W = 4;
    localparam int MAXC  = (1 << CNT_W) - 1;

    typedef struct packed {
        logic            rw, mw, j, b, as;
        logic [1:0]      rs;
        logic [2:0]      alu;
        logic [XLEN-1:0] rd1, rd2, imm, pc, pc4;
        logic [4:0]      rs1, rs2, rd;
        logic            v;
    } stage_t;

    typedef struct packed {
        stage_t     e;
        logic [7:0] cnt;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic StallE = 1'b0, FlushE = 1'b0, ClearCount = 1'b0;
    stage_t d = '0;
    stage_t a;
    logic [CNT_W-1:0] BubbleCount;

    exp_t sb[$];
    stage_t m_e = '0;
    int m_cnt = 0;
    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    decode_execute_reg #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .StallE(StallE), .FlushE(FlushE), .ClearCount(ClearCount),
        .ValidD(d.v), .RegWriteD(d.rw), .MemWriteD(d.mw), .JumpD(d.j), .BranchD(d.b),
        .ALUSrcD(d.as), .ResultSrcD(d.rs), .ALUControlD(d.alu),
        .RD1D(d.rd1), .RD2D(d.rd2), .ImmExtD(d.imm), .PCD(d.pc), .PCPlus4D(d.pc4),
        .Rs1D(d.rs1), .Rs2D(d.rs2), .RdD(d.rd),
        .RegWriteE(a.rw), .MemWriteE(a.mw), .JumpE(a.j), .BranchE(a.b),
        .ALUSrcE(a.as), .ResultSrcE(a.rs), .ALUControlE(a.alu),
        .RD1E(a.rd1), .RD2E(a.rd2), .ImmExtE(a.imm), .PCE(a.pc), .PCPlus4E(a.pc4),
        .Rs1E(a.rs1), .Rs2E(a.rs2), .RdE(a.rd), .ValidE(a.v), .BubbleCount(BubbleCount)
    );

    function automatic void check_state(string name, stage_t exp_e, int exp_cnt);
        total++;
        if (a !== exp_e) begin
            bad++;
            $display("FAIL %s stage: got %h want %h", name, a, exp_e);
        end
        total++;
        if (int'(BubbleCount) != exp_cnt) begin
            bad++;
            $display("FAIL %s count: got %0d want %0d", name, BubbleCount, exp_cnt);
        end
    endfunction

    // Monitor: one expected entry per clock edge, sampled mid-cycle
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t x;
            x = sb.pop_front();
            check_state("cycle", x.e, int'(x.cnt));
        end
    end

    function automatic stage_t rand_d();
        stage_t r;
        r.rw  = 1'($urandom);  r.mw = 1'($urandom);
        r.j   = 1'($urandom);  r.b  = 1'($urandom);
        r.as  = 1'($urandom);  r.rs = 2'($urandom);
        r.alu = 3'($urandom);
        r.rd1 = $urandom;      r.rd2 = $urandom;
        r.imm = $urandom;      r.pc  = $urandom;
        r.pc4 = $urandom;
        r.rs1 = 5'($urandom);  r.rs2 = 5'($urandom);
        r.rd  = 5'($urandom);
        r.v   = ($urandom_range(0, 3) != 0);
        return r;
    endfunction

    // Reference: E takes D (control gated by validity), nothing on stall, empty on flush
    task automatic step(stage_t nd, logic fl, logic st, logic cl);
        bit bub;
        @(negedge clk);
        #1;
        rst = 1'b0;
        d = nd; FlushE = fl; StallE = st; ClearCount = cl;
        bub = 0;
        if (fl) begin
            m_e = '0;
            bub = 1;
        end else if (!st) begin
            m_e = nd;
            if (!nd.v) begin
                m_e.rw = 0; m_e.mw = 0; m_e.j = 0; m_e.b = 0;
                bub = 1;
            end
        end
        if (cl) m_cnt = 0;
        else if (bub) m_cnt = (m_cnt + 1 > MAXC) ? MAXC : m_cnt + 1;
        sb.push_back('{e: m_e, cnt: 8'(m_cnt)});
    endtask

    task automatic async_reset();
        stage_t nd;
        @(negedge clk);
        #3;
        nd = rand_d();
        nd.v = 1; nd.rd = 5'd17; nd.rw = 1;
        d = nd; FlushE = 1'b0; StallE = 1'b0; ClearCount = 1'b0;
        rst = 1'b1;
        m_e = '0;
        m_cnt = 0;
        #1;
        check_state("reset_async", m_e, 0);
    endtask

    initial begin
        stage_t nd;
        async_reset();

        nd = '0; nd.v = 1; nd.rd = 5; nd.rs1 = 3; nd.rd1 = 32'hDEADBEEF; nd.rw = 1;
        step(nd, 0, 0, 0);

        nd = rand_d(); nd.v = 1; nd.rd = 7;
        step(nd, 0, 0, 0);
        nd.rd = 9;
        for (int i = 0; i < 3; i++) step(nd, 0, 1, 0);
        step(nd, 0, 0, 0);

        nd = rand_d(); nd.v = 1; nd.rw = 1; nd.rd = 4; nd.rs1 = 5'd31;
        step(nd, 1, 1, 0);

        nd = rand_d(); nd.v = 0; nd.rw = 1; nd.mw = 1; nd.rd = 6;
        step(nd, 0, 0, 0);

        nd = rand_d(); nd.v = 0;
        step(nd, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(nd, 0, 1, 0);

        for (int i = 0; i < 20; i++) step(rand_d(), 1, 0, 0);
        step(rand_d(), 1, 0, 1);
        step(rand_d(), 0, 1, 1);

        for (int i = 0; i < 400; i++) begin
            if (i % 97 == 50) async_reset();
            step(rand_d(), $urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0,
                 $urandom_range(0, 15) == 0);
        end

        @(negedge clk);
        @(negedge clk);
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending want 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule
